// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage: result entry layout and
// output-register source selection.
package wb_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering LSU results that lost arbitration for the
// register-file write port. Pointers carry an extra wrap bit for full/empty.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  wb_entry_t   mem_q [Depth];
  wb_entry_t   mem_d [Depth];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_i) begin
      mem_d[wptr_q[AW-1:0]] = push_entry_i;
      wptr_d                = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_i) begin
      rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU and LSU results onto the single register-file
// write port, tracks pending long-latency destinations and forwards the write.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned XLEN       = wb_pkg::XLEN,
  parameter int unsigned REG_ADDR_W = wb_pkg::REG_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_long,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] query_rs1,
  input  logic [REG_ADDR_W-1:0] query_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [XLEN-1:0]       fwd_data,
  output logic                  stall_req,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] Write_Reg,
  output logic [XLEN-1:0]       Write_Data
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_W;

  logic      alu_take, lsu_hs, lsu_keep;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  wb_entry_t fifo_head, lsu_entry;
  wb_src_e   src;

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0]       write_data_q, write_data_d;
  logic [NumRegs-1:0]    pending_q, pending_d;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  // Arbitration: ALU > FIFO head > direct LSU. rd==0 never claims the port.
  always_comb begin
    alu_take  = alu_valid && (alu_rd != '0);
    fifo_pop  = !alu_take && !fifo_empty;
    lsu_ready = !rst && (!fifo_full || fifo_pop);
    lsu_hs    = lsu_valid && lsu_ready;
    lsu_keep  = lsu_hs && (lsu_rd != '0);
    if (alu_take)                    src = SRC_ALU;
    else if (!fifo_empty)            src = SRC_FIFO;
    else if (lsu_keep)               src = SRC_LSU;
    else                             src = SRC_NONE;
    fifo_push = lsu_keep && (src != SRC_LSU);
    stall_req = fifo_full;
  end

  wb_result_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (fifo_push),
    .push_entry_i (lsu_entry),
    .pop_i        (fifo_pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    pending_d    = pending_q;
    unique case (src)
      SRC_ALU: begin
        reg_write_d  = 1'b1;
        write_reg_d  = alu_rd;
        write_data_d = alu_data;
      end
      SRC_FIFO: begin
        reg_write_d            = 1'b1;
        write_reg_d            = fifo_head.rd;
        write_data_d           = fifo_head.data;
        pending_d[fifo_head.rd] = 1'b0;
      end
      SRC_LSU: begin
        reg_write_d       = 1'b1;
        write_reg_d       = lsu_rd;
        write_data_d      = lsu_data;
        pending_d[lsu_rd] = 1'b0;
      end
      SRC_NONE: ;
    endcase
    // Set applied after clear so a same-cycle reissue stays pending.
    if (issue_long && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign RegWrite    = reg_write_q;
  assign Write_Reg   = write_reg_q;
  assign Write_Data  = write_data_q;
  assign fwd_data    = write_data_q;
  assign rs1_busy    = pending_q[query_rs1];
  assign rs2_busy    = pending_q[query_rs2];
  assign fwd_rs1_hit = reg_write_q && (write_reg_q == query_rs1) && (query_rs1 != '0);
  assign fwd_rs2_hit = reg_write_q && (write_reg_q == query_rs2) && (query_rs2 != '0);

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: a queue-based reference model predicts
// each cycle's register-file write; a monitor compares on the falling edge.
module tb_writeback_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_long;
  logic [4:0]  alu_rd, lsu_rd, issue_rd, query_rs1, query_rs2;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, rs1_busy, rs2_busy, fwd_rs1_hit, fwd_rs2_hit, stall_req;
  logic [31:0] fwd_data, Write_Data;
  logic [4:0]  Write_Reg;
  logic        RegWrite;

  always #5 clk = ~clk;

  writeback_unit #(
    .XLEN       (32),
    .REG_ADDR_W (5),
    .FIFO_DEPTH (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .issue_long  (issue_long),
    .issue_rd    (issue_rd),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .fwd_rs1_hit (fwd_rs1_hit),
    .fwd_rs2_hit (fwd_rs2_hit),
    .fwd_data    (fwd_data),
    .stall_req   (stall_req),
    .RegWrite    (RegWrite),
    .Write_Reg   (Write_Reg),
    .Write_Data  (Write_Data)
  );

  typedef struct {bit we; bit [4:0] rd; bit [31:0] data;} exp_t;
  typedef struct {bit [4:0] rd; bit [31:0] data;} res_t;

  exp_t exp_q[$];   // expected port state, one entry per cycle
  res_t mq[$];      // model of LSU results waiting for the port
  bit   pend[32];
  exp_t cur = '{1'b0, 5'd0, 32'd0};
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
      check("Write_Reg", {27'd0, Write_Reg}, {27'd0, e.rd});
      check("Write_Data", Write_Data, e.data);
    end
  end

  // Drive one cycle of stimulus, check combinational outputs, predict the next write.
  task automatic step(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit lv, input bit [4:0] lrd, input bit [31:0] ld,
                      input bit il, input bit [4:0] ird, input bit [4:0] q1, input bit [4:0] q2);
    bit   alu_w, exp_ready, hs, direct;
    exp_t nx;
    res_t h;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    issue_long = il; issue_rd = ird; query_rs1 = q1; query_rs2 = q2;
    #1;
    alu_w     = av && (ard != 0);
    exp_ready = !r && (mq.size() < D || (!alu_w && mq.size() > 0));
    check("lsu_ready", {31'd0, lsu_ready}, {31'd0, exp_ready});
    check("stall_req", {31'd0, stall_req}, {31'd0, mq.size() == D});
    check("rs1_busy", {31'd0, rs1_busy}, {31'd0, pend[q1]});
    check("rs2_busy", {31'd0, rs2_busy}, {31'd0, pend[q2]});
    check("fwd_rs1_hit", {31'd0, fwd_rs1_hit}, {31'd0, cur.we && cur.rd == q1 && q1 != 0});
    check("fwd_rs2_hit", {31'd0, fwd_rs2_hit}, {31'd0, cur.we && cur.rd == q2 && q2 != 0});
    check("fwd_data", fwd_data, cur.data);
    hs = lv && exp_ready;
    direct = 1'b0;
    nx = cur;
    nx.we = 1'b0;
    if (r) begin
      nx = '{1'b0, 5'd0, 32'd0};
      mq.delete();
      foreach (pend[i]) pend[i] = 1'b0;
    end else begin
      if (alu_w) begin
        nx = '{1'b1, ard, ad};
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        nx = '{1'b1, h.rd, h.data};
        pend[h.rd] = 1'b0;
      end else if (hs && lrd != 0) begin
        nx = '{1'b1, lrd, ld};
        pend[lrd] = 1'b0;
        direct = 1'b1;
      end
      if (hs && lrd != 0 && !direct) mq.push_back('{lrd, ld});
      if (il && ird != 0) pend[ird] = 1'b1;
    end
    @(posedge clk);
    exp_q.push_back(nx);
    cur = nx;
    @(negedge clk);
  endtask

  task automatic idle(input bit [4:0] q1, input bit [4:0] q2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  initial begin
    bit       av, lv, il;
    bit [4:0] ird;
    rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0; lsu_valid = 0; lsu_rd = 0;
    lsu_data = 0; issue_long = 0; issue_rd = 0; query_rs1 = 0; query_rs2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic ALU write
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 5);

    // Long op to x7 returns alongside an ALU write to x3
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 1, 3, 32'h33, 1, 7, 32'h1234, 0, 0, 7, 3);
    idle(7, 3);
    idle(7, 0);
    idle(7, 0);

    // Continuous ALU with three back-to-back LSU results
    for (int i = 0; i < 5; i++)
      step(0, mq.size() < D, 5'(10 + i), 32'hA000 + i, i < 3, 5'(20 + i), 32'hB000 + i,
           0, 0, 20, 21);
    repeat (3) idle(20, 22);

    // rd=0 on either source
    step(0, 1, 0, 32'hBAD, 1, 9, 32'h55, 0, 0, 9, 0);
    step(0, 0, 0, 0, 1, 0, 32'h77, 0, 0, 9, 0);
    idle(0, 0);

    // Same-cycle issue and writeback of x4: set wins
    step(0, 0, 0, 0, 1, 4, 32'h44, 1, 4, 4, 0);
    idle(4, 0);

    // Reset with a full FIFO and pending destinations
    step(0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0);
    step(0, 1, 1, 32'h1, 1, 12, 32'hC, 1, 12, 11, 12);
    step(0, 1, 2, 32'h2, 1, 13, 32'hD, 1, 13, 12, 13);
    step(1, 0, 0, 0, 1, 14, 32'hE, 0, 0, 11, 12);
    step(1, 0, 0, 0, 1, 14, 32'hE, 0, 0, 13, 11);
    idle(11, 13);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      av  = ($urandom_range(0, 2) != 0) && (mq.size() < D);
      lv  = $urandom_range(0, 1);
      ird = 5'($urandom_range(1, 15));
      il  = ($urandom_range(0, 3) == 0) && !pend[ird];
      step(0, av, 5'($urandom_range(0, 15)), $urandom, lv, 5'($urandom_range(0, 15)),
           $urandom, il, ird, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    repeat (4) idle(0, 0);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
